// File: rtl/row_scan_decoder.sv
// Registered one-hot row driver: manual address decode or automatic DWELL-paced scan with frame_done on wrap.
// Optional anti-ghosting blank cycle on every row change is enabled by defining ROW_SCAN_BLANK_GAP_EN.
module row_scan_decoder #(
    parameter int ADDR_W = 3,
    parameter int DWELL  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nen,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(1<<ADDR_W)-1:0]   row_sel,
    output logic [ADDR_W-1:0]        row_idx,
    output logic                     frame_done
);

    localparam int N  = 1 << ADDR_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

`ifdef ROW_SCAN_BLANK_GAP_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // ADVANCE is the blank cycle between two rows; it is only entered when blanking is built in.
    typedef enum logic {
        SHOW    = 1'b0,
        ADVANCE = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic [N-1:0]    sel_nxt;
    logic            fd_nxt;

    function automatic logic [N-1:0] onehot(input logic [ADDR_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SHOW;
            cnt        <= '0;
            row_idx    <= '0;
            row_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            row_idx    <= idx_nxt;
            row_sel    <= sel_nxt;
            frame_done <= fd_nxt;
        end
    end

    // Disabled cycles blank the rows but freeze row, dwell count and any pending blank.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = row_idx;
        sel_nxt   = '0;
        fd_nxt    = 1'b0;
        if (!nen) begin
            case (state)
                ADVANCE: begin
                    if (!mode && addr != row_idx) begin
                        idx_nxt = addr;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = SHOW;
                        sel_nxt   = onehot(row_idx);
                        if (!mode) begin
                            cnt_nxt = '0;
                        end
                    end
                end
                default: begin
                    if (!mode) begin
                        cnt_nxt = '0;
                        idx_nxt = addr;
                        if (BLANK && addr != row_idx) begin
                            state_nxt = ADVANCE;
                        end else begin
                            sel_nxt = onehot(addr);
                        end
                    end else if (cnt == LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = row_idx + 1'b1;
                        fd_nxt  = (row_idx == '1);
                        if (BLANK) begin
                            state_nxt = ADVANCE;
                        end else begin
                            sel_nxt = onehot(row_idx + 1'b1);
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        sel_nxt = onehot(row_idx);
                    end
                end
            endcase
        end
    end

endmodule
